delay_port_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares the single request port of `delay_master` between `n_req` requesters, such as the DSP core and auxiliary modulation or reset engines. It serialises delay-line reads and writes and performs a read-then-write pair as one atomic grant. It returns read data and a per-requester done pulse. A watchdog keeps the port from locking up if `delay_master` never answers.

---
 rtl/delay_arb_pkg.sv | 37 +++
 rtl/delay_port_arbiter_rr_picker.sv | 28 ++
 rtl/delay_port_arbiter.sv | 158 +++++++++++++++
 tb/tb_delay_port_arbiter.sv | 433 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/delay_arb_pkg.sv
// rtl/delay_arb_pkg.sv - shared state encodings and round-robin search for delay_port_arbiter
package delay_arb_pkg;

    typedef enum logic [2:0] {
        ARB_IDLE,
        ARB_ISSUE_RD,
        ARB_WAIT_RD,
        ARB_ISSUE_WR,
        ARB_WAIT_WR,
        ARB_DONE
    } arb_state_t;

    localparam int rr_max_req = 8;

    // First pending index found at offsets 1..n from last, wrapping modulo n.
    // Offsets are scanned far to near so the nearest hit is the one kept;
    // offset n is last itself, so a lone repeat requester is granted again.
    function automatic logic [2:0] rr_search(
        input logic [7:0] pending,
        input logic [2:0] last,
        input int         n
    );
        logic [2:0] pick;
        logic [2:0] idx;
        pick = last;
        for (int i = rr_max_req; i >= 1; i--) begin
            if (i <= n) begin
                idx = 3'((int'(last) + i) % n);
                if (pending[idx]) begin
                    pick = idx;
                end
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/delay_port_arbiter_rr_picker.sv
// rtl/delay_port_arbiter_rr_picker.sv - combinational round-robin pick of the next requester
module rr_picker
    import delay_arb_pkg::*;
#(
    parameter int n_req = 4,
    parameter int iw    = 2
) (
    input  logic [n_req-1:0] pending,
    input  logic [iw-1:0]    last_grant,
    output logic [iw-1:0]    grant,
    output logic             any
);

    logic [7:0] pending_ext;
    logic [2:0] last_ext;

    // Widen operands to the fixed size the search function works on.
    always_comb begin
        pending_ext = '0;
        pending_ext[n_req-1:0] = pending;
        last_ext = '0;
        last_ext[iw-1:0] = last_grant;
    end

    assign grant = iw'(rr_search(pending_ext, last_ext, n_req));
    assign any   = |pending;

endmodule

// File: rtl/delay_port_arbiter.sv
// rtl/delay_port_arbiter.sv - round-robin sequencer sharing the delay_master request port
module delay_port_arbiter
    import delay_arb_pkg::*;
#(
    parameter int data_width     = 16,
    parameter int n_req          = 4,
    parameter int timeout_cycles = 64,
    localparam int iw            = $clog2(n_req),
    localparam int cw            = $clog2(timeout_cycles + 1)
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [n_req-1:0]            req_read,
    input  logic [n_req-1:0]            req_write,
    input  logic [n_req*data_width-1:0] req_handle,
    input  logic [n_req*data_width-1:0] req_wdata,
    input  logic [n_req*data_width-1:0] req_winc,
    output logic [n_req-1:0]            req_done,
    output logic [data_width-1:0]       req_rdata,
    output logic                        dm_read_req,
    output logic                        dm_write_req,
    output logic [data_width-1:0]       dm_handle,
    output logic [data_width-1:0]       dm_write_data,
    output logic [data_width-1:0]       dm_write_inc,
    input  logic [data_width-1:0]       dm_read_data,
    input  logic                        dm_read_valid,
    input  logic                        dm_write_ack,
    output logic [iw-1:0]               grant_idx,
    output logic                        timeout_err
);

    arb_state_t    state;
    arb_state_t    state_next;
    logic [iw-1:0] last_grant;
    logic [iw-1:0] pick_idx;
    logic          pick_any;
    logic          lat_wr;
    logic          do_grant;
    logic          cap_rd;
    logic          wd_fire;
    logic          wd_expired;
    logic [cw-1:0] wd_cnt;

    rr_picker #(
        .n_req (n_req),
        .iw    (iw)
    ) u_picker (
        .pending    (req_read | req_write),
        .last_grant (last_grant),
        .grant      (pick_idx),
        .any        (pick_any)
    );

    // The count is cleared while issuing, so it measures cycles spent waiting.
    assign wd_expired = (wd_cnt == cw'(timeout_cycles - 1));

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ARB_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode, one-cycle strobes and datapath enables.
    always_comb begin
        state_next   = state;
        dm_read_req  = 1'b0;
        dm_write_req = 1'b0;
        req_done     = '0;
        do_grant     = 1'b0;
        cap_rd       = 1'b0;
        wd_fire      = 1'b0;
        case (state)
            ARB_IDLE: begin
                if (pick_any) begin
                    do_grant   = 1'b1;
                    state_next = req_read[pick_idx] ? ARB_ISSUE_RD : ARB_ISSUE_WR;
                end
            end
            ARB_ISSUE_RD: begin
                dm_read_req = 1'b1;
                state_next  = ARB_WAIT_RD;
            end
            ARB_WAIT_RD: begin
                if (dm_read_valid) begin
                    cap_rd     = 1'b1;
                    state_next = lat_wr ? ARB_ISSUE_WR : ARB_DONE;
                end else if (wd_expired) begin
                    wd_fire    = 1'b1;
                    state_next = ARB_DONE;
                end
            end
            ARB_ISSUE_WR: begin
                dm_write_req = 1'b1;
                state_next   = ARB_WAIT_WR;
            end
            ARB_WAIT_WR: begin
                if (dm_write_ack) begin
                    state_next = ARB_DONE;
                end else if (wd_expired) begin
                    wd_fire    = 1'b1;
                    state_next = ARB_DONE;
                end
            end
            ARB_DONE: begin
                req_done[grant_idx] = 1'b1;
                state_next          = ARB_IDLE;
            end
            default: begin
                state_next = ARB_IDLE;
            end
        endcase
    end

    // Grant latching, read-data capture and the sticky watchdog flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            grant_idx     <= '0;
            last_grant    <= iw'(n_req - 1);
            dm_handle     <= '0;
            dm_write_data <= '0;
            dm_write_inc  <= '0;
            lat_wr        <= 1'b0;
            req_rdata     <= '0;
            timeout_err   <= 1'b0;
        end else begin
            if (do_grant) begin
                grant_idx     <= pick_idx;
                last_grant    <= pick_idx;
                dm_handle     <= req_handle[pick_idx*data_width +: data_width];
                dm_write_data <= req_wdata[pick_idx*data_width +: data_width];
                dm_write_inc  <= req_winc[pick_idx*data_width +: data_width];
                lat_wr        <= req_write[pick_idx];
            end
            if (cap_rd) begin
                req_rdata <= dm_read_data;
            end
            if (wd_fire) begin
                req_rdata   <= '0;
                timeout_err <= 1'b1;
            end
        end
    end

    // Watchdog count: restarts on every issue, advances only while waiting.
    always_ff @(posedge clk) begin
        if (reset) begin
            wd_cnt <= '0;
        end else if (state == ARB_ISSUE_RD || state == ARB_ISSUE_WR) begin
            wd_cnt <= '0;
        end else if (state == ARB_WAIT_RD || state == ARB_WAIT_WR) begin
            wd_cnt <= wd_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_delay_port_arbiter.sv
// tb/tb_delay_port_arbiter.sv - scoreboard bench for delay_port_arbiter
module tb_delay_port_arbiter;

    localparam int dw = 16;
    localparam int n  = 4;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic [n-1:0]    req_read = '0;
    logic [n-1:0]    req_write = '0;
    logic [n*dw-1:0] req_handle = '0;
    logic [n*dw-1:0] req_wdata = '0;
    logic [n*dw-1:0] req_winc = '0;
    logic [n-1:0]    req_done;
    logic [dw-1:0]   req_rdata;
    logic            dm_read_req;
    logic            dm_write_req;
    logic [dw-1:0]   dm_handle;
    logic [dw-1:0]   dm_write_data;
    logic [dw-1:0]   dm_write_inc;
    logic [dw-1:0]   dm_read_data = '0;
    logic            dm_read_valid = 1'b0;
    logic            dm_write_ack = 1'b0;
    logic [1:0]      grant_idx;
    logic            timeout_err;

    typedef struct {
        int          idx;
        logic [15:0] rdata;
    } exp_t;

    exp_t        sb[$];
    logic [47:0] wr_log[$];
    int          checks = 0;
    int          failures = 0;
    bit          mute = 1'b0;
    bit          stray_ack = 1'b0;
    bit          rd_pend = 1'b0;
    bit          wr_pend = 1'b0;
    logic [15:0] rd_val = '0;

    delay_port_arbiter #(
        .data_width     (dw),
        .n_req          (n),
        .timeout_cycles (64)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .req_read      (req_read),
        .req_write     (req_write),
        .req_handle    (req_handle),
        .req_wdata     (req_wdata),
        .req_winc      (req_winc),
        .req_done      (req_done),
        .req_rdata     (req_rdata),
        .dm_read_req   (dm_read_req),
        .dm_write_req  (dm_write_req),
        .dm_handle     (dm_handle),
        .dm_write_data (dm_write_data),
        .dm_write_inc  (dm_write_inc),
        .dm_read_data  (dm_read_data),
        .dm_read_valid (dm_read_valid),
        .dm_write_ack  (dm_write_ack),
        .grant_idx     (grant_idx),
        .timeout_err   (timeout_err)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] model_rd(input logic [15:0] h);
        return h ^ 16'h1237;
    endfunction

    // delay_master model: answers a strobe seen in one cycle during the next cycle.
    always @(posedge clk) begin
        #1;
        dm_read_valid = rd_pend;
        dm_read_data  = rd_pend ? rd_val : 16'h0000;
        dm_write_ack  = wr_pend | stray_ack;
        rd_pend = dm_read_req && !mute;
        rd_val  = model_rd(dm_handle);
        wr_pend = dm_write_req && !mute;
        if (dm_write_req) wr_log.push_back({dm_handle, dm_write_data, dm_write_inc});
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic set_req(input int i, input bit rd, input bit wr,
                           input logic [15:0] h, input logic [15:0] wd, input logic [15:0] wi);
        req_read[i]            = rd;
        req_write[i]           = wr;
        req_handle[i*dw +: dw] = h;
        req_wdata[i*dw +: dw]  = wd;
        req_winc[i*dw +: dw]   = wi;
    endtask

    task automatic clear_req(input int i);
        set_req(i, 1'b0, 1'b0, 16'h0, 16'h0, 16'h0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        for (int i = 0; i < n; i++) clear_req(i);
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (req_done !== 4'b0 || req_rdata !== 16'h0) begin
            failures++;
            $display("FAIL reset_req: done=%b rdata=%h want 0", req_done, req_rdata);
        end
        checks++;
        if (dm_read_req !== 1'b0 || dm_write_req !== 1'b0) begin
            failures++;
            $display("FAIL reset_strobes: rd=%b wr=%b want 0", dm_read_req, dm_write_req);
        end
        checks++;
        if (dm_handle !== 16'h0 || dm_write_data !== 16'h0 || dm_write_inc !== 16'h0) begin
            failures++;
            $display("FAIL reset_dm_bus: h=%h d=%h i=%h want 0", dm_handle, dm_write_data, dm_write_inc);
        end
        checks++;
        if (grant_idx !== 2'd0 || timeout_err !== 1'b0) begin
            failures++;
            $display("FAIL reset_status: grant=%0d terr=%b want 0", grant_idx, timeout_err);
        end
    endtask

    task automatic test_single_read();
        exp_t e;
        e.idx = 2;
        e.rdata = 16'h1234;
        sb.push_back(e);
        set_req(2, 1'b1, 1'b0, 16'h0003, 16'h0, 16'h0);
        tick();
        checks++;
        if (dm_read_req !== 1'b1 || dm_handle !== 16'h0003) begin
            failures++;
            $display("FAIL single_issue: rd_req=%b handle=%h want 1/0003", dm_read_req, dm_handle);
        end
        tick();
        tick();
        checks++;
        if (req_done !== 4'(1 << e.idx)) begin
            failures++;
            $display("FAIL single_done: done=%b want %b in cycle 3", req_done, 4'(1 << e.idx));
        end
        if (req_done != 0) begin
            e = sb.pop_front();
            checks++;
            if (req_rdata !== e.rdata || grant_idx !== 2'(e.idx)) begin
                failures++;
                $display("FAIL single_data: rdata=%h grant=%0d want %h/%0d", req_rdata, grant_idx, e.rdata, e.idx);
            end
        end
        clear_req(2);
        tick();
        checks++;
        if (req_done !== 4'b0) begin
            failures++;
            $display("FAIL single_pulse: done=%b want 0", req_done);
        end
    endtask

    task automatic test_rw_pair();
        exp_t e;
        int ndone = 0;
        int done_c = 0;
        logic [47:0] w;
        e.idx = 0;
        e.rdata = model_rd(16'h0005);
        sb.push_back(e);
        wr_log.delete();
        set_req(0, 1'b1, 1'b1, 16'h0005, 16'h0A0A, 16'h0001);
        for (int c = 1; c <= 8; c++) begin
            tick();
            if (c == 1) begin
                checks++;
                if (dm_read_req !== 1'b1 || dm_write_req !== 1'b0) begin
                    failures++;
                    $display("FAIL rw_read_issue: rd=%b wr=%b want 1/0", dm_read_req, dm_write_req);
                end
            end
            if (c == 3) begin
                checks++;
                if (dm_write_req !== 1'b1 || dm_write_data !== 16'h0A0A || dm_write_inc !== 16'h0001) begin
                    failures++;
                    $display("FAIL rw_write_issue: wr=%b data=%h inc=%h want 1/0a0a/0001", dm_write_req, dm_write_data, dm_write_inc);
                end
            end
            if (req_done != 0) begin
                ndone++;
                done_c = c;
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    checks++;
                    if (req_done !== 4'(1 << e.idx) || req_rdata !== e.rdata) begin
                        failures++;
                        $display("FAIL rw_result: done=%b rdata=%h want %b/%h", req_done, req_rdata, 4'(1 << e.idx), e.rdata);
                    end
                end
                clear_req(0);
            end
        end
        checks++;
        if (ndone != 1 || done_c != 5) begin
            failures++;
            $display("FAIL rw_done_count: pulses=%0d cycle=%0d want 1 at 5", ndone, done_c);
        end
        checks++;
        w = (wr_log.size() == 1) ? wr_log.pop_front() : 48'h0;
        if (w !== {16'h0005, 16'h0A0A, 16'h0001}) begin
            failures++;
            $display("FAIL rw_write_log: got %h want 00050a0a0001", w);
        end
    endtask

    task automatic test_write_only();
        int c = 0;
        logic [47:0] w;
        wr_log.delete();
        set_req(3, 1'b0, 1'b1, 16'h0042, 16'hBEEF, 16'h0003);
        tick();
        c = 1;
        checks++;
        if (dm_write_req !== 1'b1 || dm_read_req !== 1'b0) begin
            failures++;
            $display("FAIL wo_issue: wr=%b rd=%b want 1/0", dm_write_req, dm_read_req);
        end
        while (req_done == 0 && c < 20) begin
            tick();
            c++;
        end
        checks++;
        if (c != 3 || req_done !== 4'b1000) begin
            failures++;
            $display("FAIL wo_done: cycle=%0d done=%b want 3/1000", c, req_done);
        end
        clear_req(3);
        tick();
        checks++;
        w = (wr_log.size() == 1) ? wr_log.pop_front() : 48'h0;
        if (w !== {16'h0042, 16'hBEEF, 16'h0003}) begin
            failures++;
            $display("FAIL wo_write_log: got %h want 0042beef0003", w);
        end
    endtask

    task automatic test_round_robin();
        exp_t e;
        int got = 0;
        int last_c = 0;
        int c = 0;
        do_reset();
        for (int i = 0; i < 5; i++) begin
            e.idx = i % 4;
            e.rdata = model_rd(16'(16'h0010 + (i % 4)));
            sb.push_back(e);
        end
        for (int i = 0; i < n; i++) set_req(i, 1'b1, 1'b0, 16'(16'h0010 + i), 16'h0, 16'h0);
        while (got < 5 && c < 60) begin
            tick();
            c++;
            if (req_done != 0) begin
                e = sb.pop_front();
                checks++;
                if (req_done !== 4'(1 << e.idx) || grant_idx !== 2'(e.idx)) begin
                    failures++;
                    $display("FAIL rr_order: done=%b grant=%0d want requester %0d", req_done, grant_idx, e.idx);
                end
                checks++;
                if (req_rdata !== e.rdata) begin
                    failures++;
                    $display("FAIL rr_rdata: got %h want %h", req_rdata, e.rdata);
                end
                if (got > 0) begin
                    checks++;
                    if (c - last_c != 4) begin
                        failures++;
                        $display("FAIL rr_spacing: got %0d cycles want 4", c - last_c);
                    end
                end
                last_c = c;
                got++;
                if (got == 5) begin
                    for (int i = 0; i < n; i++) clear_req(i);
                end
            end
        end
        checks++;
        if (got != 5) begin
            failures++;
            $display("FAIL rr_timeout: got %0d completions want 5", got);
        end
        for (int i = 0; i < n; i++) clear_req(i);
        tick();
    endtask

    task automatic test_watchdog();
        exp_t e;
        int c = 0;
        e.idx = 1;
        e.rdata = 16'h0000;
        sb.push_back(e);
        mute = 1'b1;
        set_req(1, 1'b1, 1'b0, 16'h0007, 16'h0, 16'h0);
        while (req_done == 0 && c < 200) begin
            tick();
            c++;
            if (c == 65) begin
                checks++;
                if (timeout_err !== 1'b0) begin
                    failures++;
                    $display("FAIL wd_early: terr=%b at cycle 65 want 0", timeout_err);
                end
            end
        end
        checks++;
        if (c != 66) begin
            failures++;
            $display("FAIL wd_latency: done at cycle %0d want 66", c);
        end
        if (req_done != 0) begin
            e = sb.pop_front();
            checks++;
            if (req_done !== 4'(1 << e.idx) || req_rdata !== e.rdata || timeout_err !== 1'b1) begin
                failures++;
                $display("FAIL wd_abort: done=%b rdata=%h terr=%b want 0010/0000/1", req_done, req_rdata, timeout_err);
            end
        end
        clear_req(1);
        mute = 1'b0;
        tick();
        e.idx = 1;
        e.rdata = model_rd(16'h0009);
        sb.push_back(e);
        set_req(1, 1'b1, 1'b0, 16'h0009, 16'h0, 16'h0);
        c = 0;
        while (req_done == 0 && c < 20) begin
            tick();
            c++;
        end
        checks++;
        if (c != 3 || req_done !== 4'b0010) begin
            failures++;
            $display("FAIL wd_recover_done: cycle=%0d done=%b want 3/0010", c, req_done);
        end
        if (req_done != 0) begin
            e = sb.pop_front();
            checks++;
            if (req_rdata !== e.rdata || timeout_err !== 1'b1) begin
                failures++;
                $display("FAIL wd_recover_data: rdata=%h terr=%b want %h/1", req_rdata, timeout_err, e.rdata);
            end
        end
        clear_req(1);
        tick();
    endtask

    task automatic test_spurious_and_reset();
        int seen = 0;
        stray_ack = 1'b1;
        tick();
        stray_ack = 1'b0;
        for (int c = 0; c < 4; c++) begin
            tick();
            if (req_done != 0 || dm_write_req != 0) seen++;
        end
        checks++;
        if (seen != 0) begin
            failures++;
            $display("FAIL stray_ack: %0d cycles with activity want 0", seen);
        end
        mute = 1'b1;
        set_req(3, 1'b0, 1'b1, 16'h0020, 16'h5555, 16'h0002);
        tick();
        checks++;
        if (dm_write_req !== 1'b1) begin
            failures++;
            $display("FAIL wr_issue_before_reset: wr=%b want 1", dm_write_req);
        end
        tick();
        tick();
        reset = 1'b1;
        clear_req(3);
        tick();
        checks++;
        if (req_done !== 4'b0 || req_rdata !== 16'h0 || dm_handle !== 16'h0 || dm_write_data !== 16'h0
            || dm_write_inc !== 16'h0 || grant_idx !== 2'd0 || timeout_err !== 1'b0
            || dm_read_req !== 1'b0 || dm_write_req !== 1'b0) begin
            failures++;
            $display("FAIL mid_reset_outputs: done=%b rdata=%h h=%h d=%h i=%h g=%0d terr=%b want all 0",
                     req_done, req_rdata, dm_handle, dm_write_data, dm_write_inc, grant_idx, timeout_err);
        end
        reset = 1'b0;
        mute = 1'b0;
        seen = 0;
        for (int c = 0; c < 8; c++) begin
            tick();
            if (req_done != 0 || dm_read_req != 0 || dm_write_req != 0) seen++;
        end
        checks++;
        if (seen != 0) begin
            failures++;
            $display("FAIL post_reset_idle: %0d active cycles want 0", seen);
        end
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: %0d expected completions never seen", sb.size());
        end
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_rw_pair();
        test_write_only();
        test_round_robin();
        test_watchdog();
        test_spurious_and_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
